// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path feeding the DDR3 write FIFO.
// Holds the receiver FSM state type, the baud divider and the parity rule.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Clock cycles per bit period (integer division, truncating).
    function automatic int unsigned bit_cyc(input int unsigned clk_freq, input int unsigned bps);
        return clk_freq / bps;
    endfunction

    // Expected parity bit for a data byte: even parity makes the total XOR zero.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte UART deserialiser: 2-flop synchroniser, start validation, mid-bit
// sampling, optional parity check and stop-bit check; one-cycle result pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYC    = 5208,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output rx_state_e  o_state
);

    localparam int unsigned CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    rx_state_e        r_state;
    rx_state_e        w_state_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_err;
    logic             r_byte_valid;
    logic [7:0]       r_byte_data;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             w_fall;
    logic             w_sample;

    assign w_fall = r_rx_d & ~r_rx_s;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // START samples at half a bit period; every later bit one full period on.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_sample = (r_cnt == CNT_HALF);
                if (w_sample) begin
                    w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                w_sample = (r_cnt == CNT_LAST);
                if (w_sample && (r_bit_idx == 3'd7)) begin
                    w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_sample = (r_cnt == CNT_LAST);
                if (w_sample) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_sample = (r_cnt == CNT_LAST);
                if (w_sample) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1      <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_d       <= 1'b1;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_rx_s       <= r_sync1;
            r_rx_d       <= r_rx_s;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;

            if ((r_state == ST_IDLE) || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_sample) begin
                case (r_state)
                    ST_START: begin
                        r_bit_idx <= '0;
                        r_par_err <= 1'b0;
                    end
                    ST_DATA: begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    ST_PARITY: begin
                        r_par_err <= (r_rx_s != parity_bit(r_shift, PARITY_ODD != 0));
                    end
                    ST_STOP: begin
                        // A bad stop bit outranks a parity mismatch.
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                        end else if (r_par_err) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_state      = r_state;

endmodule

// File: rtl/uart_rx_packer.sv
// UART receiver front end for the DDR3 write FIFO: packs received bytes into
// FIFO words, reports line errors and overflow, and flushes stale partial words.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned UART_BPS      = 9600,
    parameter int unsigned FIFO_WR_BYTE  = 4,
    parameter int unsigned FIFO_WR_WIDTH = 8 * FIFO_WR_BYTE,
    parameter int unsigned MSB_FIRST     = 1,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned IDLE_TO       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic                     fifo_full,
    output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
    output logic                     fifo_wr_en,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int unsigned BIT_CYC   = bit_cyc(CLK_FREQ, UART_BPS);
    localparam int unsigned IDLE_CYC  = IDLE_TO * BIT_CYC;
    localparam logic [31:0] IDLE_LAST = (IDLE_TO == 0) ? 32'd0 : 32'(IDLE_CYC - 1);
    localparam int unsigned CNT_W     = $clog2(FIFO_WR_BYTE + 1);

    logic                     w_byte_valid;
    logic [7:0]               w_byte_data;
    logic                     w_frame_err;
    logic                     w_parity_err;
    rx_state_e                w_rx_state;
    logic                     w_rx_idle;
    logic [FIFO_WR_WIDTH-1:0] w_word_ins;
    logic [CNT_W-1:0]         w_count_inc;
    logic                     w_word_done;
    logic                     w_to_hit;

    logic [FIFO_WR_WIDTH-1:0] r_word;
    logic [CNT_W-1:0]         r_count;
    logic [31:0]              r_idle_cnt;
    logic [FIFO_WR_WIDTH-1:0] r_wr_data;
    logic                     r_wr_en;
    logic                     r_frame_err;
    logic                     r_parity_err;
    logic                     r_overflow;
    logic                     r_timeout;

    uart_rx_byte #(
        .BIT_CYC    (BIT_CYC),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) u_rx_byte (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err),
        .o_parity_err (w_parity_err),
        .o_state      (w_rx_state)
    );

    assign w_rx_idle   = (w_rx_state == ST_IDLE);
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_word_done = (w_count_inc == CNT_W'(FIFO_WR_BYTE));
    assign w_to_hit    = (IDLE_TO != 0) && w_rx_idle && (r_count != '0) && (r_idle_cnt == IDLE_LAST);

    always_comb begin
        w_word_ins = '0;
        if (MSB_FIRST != 0) begin
            w_word_ins = (r_word << 8) | FIFO_WR_WIDTH'(w_byte_data);
        end else begin
            w_word_ins = (r_word >> 8) | (FIFO_WR_WIDTH'(w_byte_data) << (FIFO_WR_WIDTH - 8));
        end
    end

    // fifo_wr_en is a bare one-cycle strobe with no ready: fifo_full is the only
    // back-pressure, and a word that meets a full FIFO is dropped with overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_count      <= '0;
            r_idle_cnt   <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;

            if (w_frame_err || w_parity_err) begin
                r_word  <= '0;
                r_count <= '0;
            end else if (w_byte_valid) begin
                if (w_word_done) begin
                    r_word  <= '0;
                    r_count <= '0;
                    if (fifo_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_word_ins;
                    end
                end else begin
                    r_word  <= w_word_ins;
                    r_count <= w_count_inc;
                end
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_word    <= '0;
                r_count   <= '0;
            end

            // Leaving IDLE (a falling edge on rx) restarts the idle window.
            if (!w_rx_idle || (r_count == '0) || w_to_hit) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end
        end
    end

    assign fifo_wr_data = r_wr_data;
    assign fifo_wr_en   = r_wr_en;
    assign frame_err    = r_frame_err;
    assign parity_err   = r_parity_err;
    assign overflow     = r_overflow;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: two instances on parallel lines (A: 4-byte MSB-first
// word, even parity, idle timeout; B: 2-byte LSB-first word, odd parity).
module tb_uart_rx_packer;

  localparam int BC       = 16;
  localparam int HB       = BC / 2;
  localparam int IDLE_CYC = 2 * BC;

  logic        clk;
  logic        rst_n;
  logic        rx_a, rx_b;
  logic        full_a, full_b;
  logic [31:0] data_a;
  logic [15:0] data_b;
  logic        wr_a, fe_a, pe_a, ov_a, to_a;
  logic        wr_b, fe_b, pe_b, ov_b, to_b;

  uart_rx_packer #(
    .CLK_FREQ(1_600_000), .UART_BPS(100_000), .FIFO_WR_BYTE(4),
    .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0), .IDLE_TO(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .fifo_full(full_a),
    .fifo_wr_data(data_a), .fifo_wr_en(wr_a), .frame_err(fe_a),
    .parity_err(pe_a), .overflow(ov_a), .timeout(to_a)
  );

  uart_rx_packer #(
    .CLK_FREQ(1_600_000), .UART_BPS(100_000), .FIFO_WR_BYTE(2),
    .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1), .IDLE_TO(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .fifo_full(full_b),
    .fifo_wr_data(data_b), .fifo_wr_en(wr_b), .frame_err(fe_b),
    .parity_err(pe_b), .overflow(ov_b), .timeout(to_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int           fwb [2] = '{4, 2};
  bit           msb [2] = '{1'b1, 1'b0};
  int           ito [2] = '{2, 0};
  string        nm  [2] = '{"A", "B"};
  logic [7:0]   part [2][16];
  int           part_n [2];
  logic [127:0] last_word [2];
  logic [127:0] exp_q [$];
  logic         e_wr [2], e_ov [2], e_fe [2], e_pe [2];
  int           tot_wr [2], tot_ov [2], tot_fe [2], tot_pe [2], tot_to [2];
  int           n_wr [2], n_ov [2], n_fe [2], n_pe [2], n_to [2];
  int           n_cmp;
  int           n_bad;

  // pulse counters catch any strobe outside the points checked directly
  always @(negedge clk) begin
    n_wr[0] += int'(wr_a); n_ov[0] += int'(ov_a); n_fe[0] += int'(fe_a);
    n_pe[0] += int'(pe_a); n_to[0] += int'(to_a);
    n_wr[1] += int'(wr_b); n_ov[1] += int'(ov_b); n_fe[1] += int'(fe_b);
    n_pe[1] += int'(pe_b); n_to[1] += int'(to_b);
  end

  function automatic logic [127:0] word_of(input int d);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < fwb[d]; k++) begin
      if (msb[d]) w = w | (128'(part[d][k]) << (8 * (fwb[d] - 1 - k)));
      else        w = w | (128'(part[d][k]) << (8 * k));
    end
    return w;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                      input bit full);
    for (int d = 0; d < 2; d++) begin
      e_wr[d] = 1'b0; e_ov[d] = 1'b0; e_fe[d] = 1'b0; e_pe[d] = 1'b0;
      if (bad_stop) begin
        e_fe[d] = 1'b1; tot_fe[d]++; part_n[d] = 0;
      end else if (bad_par) begin
        e_pe[d] = 1'b1; tot_pe[d]++; part_n[d] = 0;
      end else begin
        part[d][part_n[d]] = b;
        part_n[d]++;
        if (part_n[d] == fwb[d]) begin
          if (full) begin
            e_ov[d] = 1'b1; tot_ov[d]++;
          end else begin
            e_wr[d] = 1'b1; tot_wr[d]++;
            last_word[d] = word_of(d);
            if (d == 0) exp_q.push_back(last_word[d]);
          end
          part_n[d] = 0;
        end
      end
    end
  endfunction

  function automatic void model_gap(input int n);
    for (int d = 0; d < 2; d++) begin
      if (ito[d] > 0 && part_n[d] > 0 && n >= ito[d] * BC + 16) begin
        part_n[d] = 0; tot_to[d]++;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      part_n[d] = 0; last_word[d] = '0;
      e_wr[d] = 1'b0; e_ov[d] = 1'b0; e_fe[d] = 1'b0; e_pe[d] = 1'b0;
    end
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic wr, input logic ov, input logic fe,
                           input logic pe, input logic to, input logic [127:0] data);
    check($sformatf("%s.wr_en", nm[d]),    128'(wr), 128'(e_wr[d]));
    check($sformatf("%s.overflow", nm[d]), 128'(ov), 128'(e_ov[d]));
    check($sformatf("%s.frame_err", nm[d]), 128'(fe), 128'(e_fe[d]));
    check($sformatf("%s.parity_err", nm[d]), 128'(pe), 128'(e_pe[d]));
    check($sformatf("%s.timeout", nm[d]),  128'(to), 128'(0));
    check($sformatf("%s.wr_data", nm[d]),  data, last_word[d]);
  endtask

  task automatic check_both();
    check_dut(0, wr_a, ov_a, fe_a, pe_a, to_a, {96'd0, data_a});
    check_dut(1, wr_b, ov_b, fe_b, pe_b, to_b, {112'd0, data_b});
    if (wr_a) begin
      if (exp_q.size() == 0) check("A.unexpected_write", {96'd0, data_a}, 128'd0);
      else check("A.write_queue", {96'd0, data_a}, exp_q.pop_front());
    end
  endtask

  task automatic check_totals(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.%s.n_wr", tag, nm[d]), 128'(n_wr[d]), 128'(tot_wr[d]));
      check($sformatf("%s.%s.n_ov", tag, nm[d]), 128'(n_ov[d]), 128'(tot_ov[d]));
      check($sformatf("%s.%s.n_fe", tag, nm[d]), 128'(n_fe[d]), 128'(tot_fe[d]));
      check($sformatf("%s.%s.n_pe", tag, nm[d]), 128'(n_pe[d]), 128'(tot_pe[d]));
      check($sformatf("%s.%s.n_to", tag, nm[d]), 128'(n_to[d]), 128'(tot_to[d]));
    end
  endtask

  // drivers
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    model_gap(n);
  endtask

  // Frame bits: start, 8 data LSB first, parity, stop. Checked one clk after stop mid-sample.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] fa, fb;
    fa = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    fb = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    model_frame(b, bad_par, bad_stop, full_a);
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      rx_a = fa[i];
      rx_b = fb[i];
      if (i < 10) begin
        repeat (BC) @(posedge clk);
        #1;
      end
    end
    repeat (HB + 5) @(posedge clk);
    #1;
    check_both();
    repeat (BC - HB - 5) @(posedge clk);
    #1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    if (bad_stop) begin
      repeat (BC) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_full(input bit f);
    full_a = f;
    full_b = f;
  endtask

  initial begin
    logic [7:0] b;
    bit         bp, bs;
    logic [7:0] tb_bytes [4];
    n_cmp = 0;
    n_bad = 0;
    for (int d = 0; d < 2; d++) begin
      tot_wr[d] = 0; tot_ov[d] = 0; tot_fe[d] = 0; tot_pe[d] = 0; tot_to[d] = 0;
      n_wr[d] = 0; n_ov[d] = 0; n_fe[d] = 0; n_pe[d] = 0; n_to[d] = 0;
    end
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    set_full(1'b0);
    model_reset();

    // step 1: reset state
    repeat (5) @(posedge clk);
    #1;
    check_both();
    rst_n = 1'b1;
    idle(20);

    // step 2: basic packing 12 34 56 78
    tb_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) send_frame(tb_bytes[i], 1'b0, 1'b0);
    check("A.word_12345678", last_word[0], 128'h12345678);
    check("B.word_7856", last_word[1], 128'h7856);

    // step 3: parity error mid-word, then four good bytes
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);

    // step 4: framing errors (alone, and together with bad parity)
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h66, 1'b1, 1'b1);

    // step 5: short low glitch is a false start
    @(posedge clk);
    #1;
    rx_a = 1'b0;
    rx_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    idle(40);
    check_totals("glitch");

    // step 6: idle timeout on A, then DE AD BE EF
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle(IDLE_CYC + 40);
    check_totals("timeout");
    tb_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) send_frame(tb_bytes[i], 1'b0, 1'b0);
    check("A.word_deadbeef", last_word[0], 128'hDEADBEEF);

    // step 7: back-pressure drops complete words
    set_full(1'b1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    set_full(1'b0);

    // step 8: randomized frames, errors, back-pressure and gaps
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 7) == 0);
      set_full($urandom_range(0, 3) == 0);
      send_frame(b, bp, bs);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(IDLE_CYC + 20, IDLE_CYC + 60));
      else idle($urandom_range(0, 4));
    end
    set_full(1'b0);
    check_totals("random");

    // step 9: reset in the middle of a data bit of byte 3
    send_frame(8'h9A, 1'b0, 1'b0);
    send_frame(8'hBC, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rx_a = 1'b0;
    rx_b = 1'b0;
    repeat (BC) @(posedge clk);
    #1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (BC + HB) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    exp_q.delete();
    check_both();
    rst_n = 1'b1;
    idle(40);
    tb_bytes = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    for (int i = 0; i < 4; i++) send_frame(tb_bytes[i], 1'b0, 1'b0);
    check("A.word_after_reset", last_word[0], 128'hC0FFEE01);
    idle(10);
    check_totals("final");
    check("A.exp_q_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
